// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: keep-mask builders, popcount and the
// offset-insert state encoding.
package axis_pkg;

    // Widest keep vector any stream in this datapath uses (1024-bit data).
    localparam int KEEP_MAX_W = 128;

    typedef logic [KEEP_MAX_W-1:0] keep_wide_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BODY  = 2'd1,
        ST_FLUSH = 2'd2
    } offset_state_e;

    // Lanes 0..n-1 set; n<=0 gives an empty mask. Callers size-cast the result.
    function automatic keep_wide_t keep_ones_right(input int n);
        keep_wide_t r;
        r = '0;
        for (int i = 0; i < KEEP_MAX_W; i++) begin
            r[i] = (i < n);
        end
        return r;
    endfunction

    // Top n lanes of a kw-lane keep set (lanes kw-n..kw-1).
    function automatic keep_wide_t keep_ones_left(input int n, input int kw);
        keep_wide_t r;
        r = '0;
        for (int i = 0; i < KEEP_MAX_W; i++) begin
            r[i] = (i >= kw - n) && (i < kw);
        end
        return r;
    endfunction

    // Number of set lanes in a keep vector.
    function automatic int keep_count(input keep_wide_t k);
        int n;
        n = 0;
        for (int i = 0; i < KEEP_MAX_W; i++) begin
            if (k[i]) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/axis_byte_rotate.sv
// Combinational lane rotator: output lane j takes input lane (j - off) mod KW,
// i.e. data and keep move up by 'off' lanes with the top lanes wrapping to 0.
module axis_byte_rotate #(
    parameter int DW    = 64,
    parameter int KW    = DW / 8,
    parameter int OFF_W = $clog2(KW)
) (
    input  logic [DW-1:0]    data,
    input  logic [KW-1:0]    keep,
    input  logic [OFF_W-1:0] off,
    output logic [DW-1:0]    data_rot,
    output logic [KW-1:0]    keep_rot
);

    genvar gi;
    generate
        for (gi = 0; gi < KW; gi++) begin : g_lane
            localparam logic [OFF_W-1:0] LANE = OFF_W'(gi);
            logic [OFF_W-1:0] src;

            // KW is a power of two, so the subtraction wraps modulo KW for free
            assign src = LANE - off;
            assign data_rot[gi*8 +: 8] = data[{src, 3'b000} +: 8];
            assign keep_rot[gi]        = keep[src];
        end
    endgenerate

endmodule

// File: rtl/axis_offset_insert.sv
// Re-inserts a per-packet lane offset into a packed AXI-Stream: first beat
// starts at lane OFF (left-aligned keep), middle beats full, last beat
// right-aligned. One registered output slot; an extra FLUSH beat is emitted
// when the tail bytes spill past the last input beat.
import axis_pkg::*;

module axis_offset_insert #(
    parameter int AXIS_DW = 64,
    parameter int AXIS_KW = AXIS_DW / 8,
    parameter int OFF_W   = $clog2(AXIS_KW)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic [AXIS_DW-1:0] s_axis_tdata,
    input  logic [AXIS_KW-1:0] s_axis_tkeep,
    input  logic               s_axis_tlast,
    input  logic [OFF_W-1:0]   s_axis_offset,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [AXIS_DW-1:0] m_axis_tdata,
    output logic [AXIS_KW-1:0] m_axis_tkeep,
    output logic               m_axis_tlast
);

    offset_state_e      state_reg;
    logic [OFF_W-1:0]   off_reg;
    logic [AXIS_DW-1:0] carry_reg;
    logic [AXIS_KW-1:0] flush_keep_reg;
    logic               m_valid_reg;
    logic [AXIS_DW-1:0] m_data_reg;
    logic [AXIS_KW-1:0] m_keep_reg;
    logic               m_last_reg;

    logic               out_free;
    logic               in_fire;
    logic               first_beat;
    logic [OFF_W-1:0]   eff_off;
    logic [AXIS_DW-1:0] rot_data;
    logic [AXIS_KW-1:0] rot_keep;
    logic [AXIS_DW-1:0] merged_data;
    logic [AXIS_KW-1:0] lo_keep;

    logic [AXIS_DW-1:0] nxt_data;
    logic [AXIS_KW-1:0] nxt_keep;
    logic               nxt_last;
    offset_state_e      nxt_state;
    logic [AXIS_KW-1:0] nxt_flush_keep;
    int                 cnt_i;
    int                 off_i;
    logic               fits;

    assign out_free   = !m_valid_reg || m_axis_tready;
    // Held low while in reset and while the carry beat still has to go out
    assign s_axis_tready = rst_n && out_free && (state_reg != ST_FLUSH);
    assign in_fire    = s_axis_tvalid && s_axis_tready;
    assign first_beat = (state_reg == ST_IDLE);
    // The first beat uses the live offset; later beats use the latched one
    assign eff_off    = first_beat ? s_axis_offset : off_reg;

    axis_byte_rotate #(
        .DW    (AXIS_DW),
        .KW    (AXIS_KW),
        .OFF_W (OFF_W)
    ) u_rotate (
        .data     (s_axis_tdata),
        .keep     (s_axis_tkeep),
        .off      (eff_off),
        .data_rot (rot_data),
        .keep_rot (rot_keep)
    );

    // Lanes below the offset come from the carry, the rest from the rotated input
    genvar gi;
    generate
        for (gi = 0; gi < AXIS_KW; gi++) begin : g_merge
            localparam logic [OFF_W-1:0] LANE = OFF_W'(gi);
            assign lo_keep[gi] = (LANE < eff_off);
            assign merged_data[gi*8 +: 8] = lo_keep[gi] ? carry_reg[gi*8 +: 8]
                                                        : rot_data[gi*8 +: 8];
        end
    endgenerate

    // Build the output beat and next state for an accepted input beat
    always_comb begin
        off_i          = int'(eff_off);
        cnt_i          = keep_count(KEEP_MAX_W'(s_axis_tkeep));
        fits           = (cnt_i + off_i) <= AXIS_KW;
        nxt_data       = merged_data;
        nxt_keep       = '1;
        nxt_last       = 1'b0;
        nxt_state      = ST_BODY;
        nxt_flush_keep = flush_keep_reg;
        if (s_axis_tlast) begin
            if (fits) begin
                nxt_last  = 1'b1;
                nxt_state = ST_IDLE;
                if (first_beat) begin
                    // Short single-beat packet stays right-aligned, unshifted
                    nxt_data = s_axis_tdata;
                    nxt_keep = s_axis_tkeep;
                end else begin
                    nxt_keep = rot_keep | lo_keep;
                end
            end else begin
                nxt_state      = ST_FLUSH;
                nxt_flush_keep = AXIS_KW'(keep_ones_right(cnt_i + off_i - AXIS_KW));
                if (first_beat) begin
                    nxt_keep = AXIS_KW'(keep_ones_left(AXIS_KW - off_i, AXIS_KW));
                end
            end
        end else if (first_beat) begin
            nxt_keep = AXIS_KW'(keep_ones_left(AXIS_KW - off_i, AXIS_KW));
        end
    end

    // FSM plus output slot: load a flush or mapped beat whenever the slot frees
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            off_reg        <= '0;
            carry_reg      <= '0;
            flush_keep_reg <= '0;
            m_valid_reg    <= 1'b0;
            m_data_reg     <= '0;
            m_keep_reg     <= '0;
            m_last_reg     <= 1'b0;
        end else if (out_free) begin
            if (state_reg == ST_FLUSH) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= carry_reg;
                m_keep_reg  <= flush_keep_reg;
                m_last_reg  <= 1'b1;
                state_reg   <= ST_IDLE;
            end else if (in_fire) begin
                m_valid_reg    <= 1'b1;
                m_data_reg     <= nxt_data;
                m_keep_reg     <= nxt_keep;
                m_last_reg     <= nxt_last;
                state_reg      <= nxt_state;
                flush_keep_reg <= nxt_flush_keep;
                // Rotated lanes 0..OFF-1 are the input's top OFF bytes
                carry_reg      <= rot_data;
                if (first_beat) begin
                    off_reg <= s_axis_offset;
                end
            end else begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = m_valid_reg;
    assign m_axis_tdata  = m_data_reg;
    assign m_axis_tkeep  = m_keep_reg;
    assign m_axis_tlast  = m_last_reg;

endmodule

// File: tb/tb_axis_offset_insert.sv
// Self-checking bench for axis_offset_insert: directed cases, a FLUSH stall,
// mid-packet reset and randomized packets against a byte-stream model.
module tb_axis_offset_insert;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int OW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic [KW-1:0] s_keep = '0;
    logic          s_last = 1'b0;
    logic [OW-1:0] s_off = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [KW-1:0] m_keep;
    logic          m_last;

    int n_checks = 0;
    int n_pass   = 0;
    bit ready_rand = 1'b0;
    bit mon_en     = 1'b0;
    int beat_no    = 0;

    byte unsigned  pkt_q[$];
    logic [DW-1:0] exp_data[$];
    logic [KW-1:0] exp_keep[$];
    logic          exp_last[$];

    logic [DW-1:0]    ed;
    logic [KW-1:0]    ek;
    logic             el;
    bit               prev_stall = 1'b0;
    logic [DW+KW+1:0] prev_snap;

    axis_offset_insert #(.AXIS_DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tdata  (s_data),
        .s_axis_tkeep  (s_keep),
        .s_axis_tlast  (s_last),
        .s_axis_offset (s_off),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tkeep  (m_keep),
        .m_axis_tlast  (m_last)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [DW-1:0] lane_mask(input logic [KW-1:0] k);
        logic [DW-1:0] m;
        m = '0;
        for (int j = 0; j < KW; j++) if (k[j]) m[j*8 +: 8] = 8'hFF;
        return m;
    endfunction

    // Reference: the packet bytes laid out as a stream starting at lane 'off';
    // a packet short enough to fit one beat after the offset goes out unshifted.
    function automatic void push_expected(input int off);
        int L, total, nb, pos;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        L = pkt_q.size();
        if (L <= KW - off) begin
            d = '0; k = '0;
            for (int j = 0; j < L; j++) begin d[j*8 +: 8] = pkt_q[j]; k[j] = 1'b1; end
            exp_data.push_back(d); exp_keep.push_back(k); exp_last.push_back(1'b1);
        end else begin
            total = off + L;
            nb = (total + KW - 1) / KW;
            for (int b = 0; b < nb; b++) begin
                d = '0; k = '0;
                for (int j = 0; j < KW; j++) begin
                    pos = b * KW + j;
                    if (pos >= off && pos < total) begin
                        d[j*8 +: 8] = pkt_q[pos - off];
                        k[j] = 1'b1;
                    end
                end
                exp_data.push_back(d); exp_keep.push_back(k); exp_last.push_back(b == nb - 1);
            end
        end
    endfunction

    task automatic fill_pkt(input int len, input bit seq);
        pkt_q.delete();
        for (int i = 0; i < len; i++) pkt_q.push_back(seq ? 8'(i) : 8'($urandom));
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l, input logic [OW-1:0] o);
        bit hs;
        int waited;
        s_valid = 1'b1; s_data = d; s_keep = k; s_last = l; s_off = o;
        waited = 0;
        forever begin
            @(negedge clk);
            hs = s_ready;
            @(posedge clk);
            #1;
            if (hs) break;
            waited++;
            if (waited > 300) begin
                check_val("s_handshake_timeout", 128'(0), 128'(1));
                break;
            end
        end
        s_valid = 1'b0;
        s_off = OW'($urandom);
    endtask

    // Offset on later beats is garbage on purpose: it must be ignored
    task automatic send_packet(input int off, input int max_beats, input bit gaps);
        int L, nb, idx;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        L = pkt_q.size();
        nb = (L + KW - 1) / KW;
        for (int b = 0; b < nb && b < max_beats; b++) begin
            d = {$urandom, $urandom}; k = '0;
            for (int j = 0; j < KW; j++) begin
                idx = b * KW + j;
                if (idx < L) begin d[j*8 +: 8] = pkt_q[idx]; k[j] = 1'b1; end
            end
            send_beat(d, k, b == nb - 1, (b == 0) ? OW'(off) : OW'($urandom));
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
        end
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_data.size() != 0 && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check_val("drain_pending", 128'(exp_data.size()), 128'(0));
    endtask

    always @(posedge clk) begin
        if (ready_rand) begin
            #1;
            m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor: scoreboard compare on handshake, stability while stalled
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check_val("hold_stable", 128'({m_valid, m_data, m_keep, m_last}), 128'(prev_snap));
            if (m_valid && m_ready) begin
                $display("beat %0d: data=%h keep=%h last=%b", beat_no, m_data, m_keep, m_last);
                if (exp_data.size() == 0) begin
                    check_val("unexpected_beat", 128'(0), 128'(1));
                end else begin
                    ed = exp_data.pop_front(); ek = exp_keep.pop_front(); el = exp_last.pop_front();
                    check_val("keep", 128'(m_keep), 128'(ek));
                    check_val("last", 128'(m_last), 128'(el));
                    check_val("data", 128'(m_data & lane_mask(m_keep)), 128'(ed & lane_mask(ek)));
                    check_val("keep_nonzero", 128'(m_keep != '0), 128'(1));
                end
                beat_no++;
            end
            prev_stall = m_valid && !m_ready;
            prev_snap  = {m_valid, m_data, m_keep, m_last};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int offs [5] = '{3, 3, 6, 6, 0};
        int lens [5] = '{12, 14, 3, 2, 37};

        // Reset state
        #12;
        check_val("rst_m_valid", 128'(m_valid), 128'(0));
        check_val("rst_m_data",  128'(m_data),  128'(0));
        check_val("rst_m_keep",  128'(m_keep),  128'(0));
        check_val("rst_m_last",  128'(m_last),  128'(0));
        check_val("rst_s_ready", 128'(s_ready), 128'(0));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b1;
        mon_en = 1'b1;

        // Directed cases, sink always ready
        for (int t = 0; t < 5; t++) begin
            fill_pkt(lens[t], 1'b1);
            push_expected(offs[t]);
            send_packet(offs[t], 1000, 1'b0);
            wait_drain();
        end

        // FLUSH beat pending while the sink stalls
        fill_pkt(14, 1'b1);
        push_expected(3);
        send_packet(3, 1000, 1'b0);
        m_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_val("flush_s_ready", 128'(s_ready), 128'(0));
            check_val("flush_m_valid", 128'(m_valid), 128'(1));
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_drain();

        // Randomized packets, offsets, source gaps and sink backpressure
        ready_rand = 1'b1;
        repeat (40) begin
            int len, off;
            len = $urandom_range(1, 40);
            off = $urandom_range(0, KW - 1);
            fill_pkt(len, 1'b0);
            push_expected(off);
            send_packet(off, 1000, 1'b1);
        end
        wait_drain();
        ready_rand = 1'b0;
        @(posedge clk); #1;
        m_ready = 1'b1;

        // Mid-packet reset discards the packet
        mon_en = 1'b0;
        fill_pkt(20, 1'b0);
        send_packet(2, 1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_m_valid", 128'(m_valid), 128'(0));
        check_val("arst_m_data",  128'(m_data),  128'(0));
        check_val("arst_m_keep",  128'(m_keep),  128'(0));
        check_val("arst_m_last",  128'(m_last),  128'(0));
        check_val("arst_s_ready", 128'(s_ready), 128'(0));
        exp_data.delete(); exp_keep.delete(); exp_last.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        fill_pkt(17, 1'b1);
        push_expected(5);
        send_packet(5, 1000, 1'b0);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_offset_insert.md
# axis_offset_insert

Inverse of the stream aligner. It takes packed AXI-Stream packets, where every beat is full except a right-aligned last beat, and re-inserts a per-packet byte offset. The first output beat then starts at lane OFF and its `tkeep` is left-aligned, middle beats are full, and the last beat is right-aligned. It sits on the transmit side of the datapath, ahead of interfaces that require a lane-offset start. The output follows the same packet/keep conventions the aligner accepts on its input.

## Interface
- `AXIS_DW`, 64, data width in bits; power of two, ≥16.
- `AXIS_KW`, derived `AXIS_DW/8`, byte lanes.
- `OFF_W`, derived `$clog2(AXIS_KW)`, offset width.
- `clk` input 1 — single clock.
- `rst_n` input 1 — asynchronous, active-low reset.
- `s_axis_tvalid` input 1 — input beat valid.
- `s_axis_tready` output 1 — input accept.
- `s_axis_tdata` input AXIS_DW — input data, byte i in lane i.
- `s_axis_tkeep` input AXIS_KW — all ones, except on the last beat: ones in lanes 0..c-1, with 1≤c≤KW.
- `s_axis_tlast` input 1 — last input beat.
- `s_axis_offset` input OFF_W — packet offset OFF; sampled only on the first beat's handshake.
- `m_axis_tvalid` output 1, `m_axis_tready` input 1, `m_axis_tdata` output AXIS_DW, `m_axis_tkeep` output AXIS_KW, `m_axis_tlast` output 1 — output stream.

## Operation
- States:
  - IDLE: awaiting the first beat.
  - BODY: packet in progress.
  - FLUSH: emitting the leftover carry beat.
- First-beat handshake in IDLE:
  - Latch OFF.
  - Carry register takes input lanes KW-OFF..KW-1.
- Non-last beat mapping:
  - Output lanes 0..OFF-1 hold the previous carry; the first beat of a packet has keep 0 there.
  - Output lanes OFF..KW-1 hold input lanes 0..KW-OFF-1.
  - Carry is then updated from input lanes KW-OFF..KW-1.
- Last input beat with c bytes, multi-beat packet:
  - c ≤ KW-OFF: one output beat with keep = lanes 0..OFF+c-1 and tlast; go to IDLE.
  - c > KW-OFF: one full beat with no tlast, then FLUSH emits keep = lanes 0..c-(KW-OFF)-1 with tlast.
- Single-beat packet (first beat carries tlast):
  - c ≤ KW-OFF: emitted unshifted; keep and data equal the input; tlast. The right-aligned rule wins.
  - c > KW-OFF: first beat keep = lanes OFF..KW-1; FLUSH beat keep = lanes 0..c-(KW-OFF)-1 with tlast.
- OFF=0: pure passthrough; beat count is unchanged.
- Output beats = input beats, or input beats +1. Byte order is preserved exactly. Output keep is never zero.
- Reset mid-packet discards the packet; the next beat after reset is treated as a first beat.

## Timing
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tkeep`=0, `m_axis_tlast`=0, `s_axis_tready`=0.
  - State IDLE; carry and OFF = 0.
- Output register stage: latency from input handshake to `m_axis_tvalid` is 1 cycle.
- `s_axis_tready` = `!m_axis_tvalid || m_axis_tready`, and is forced 0 in FLUSH.
- The FLUSH beat loads in the cycle the output slot frees. It can therefore be presented in the cycle after the last full beat is accepted.
- Output holds data, keep and last stable while `m_axis_tvalid && !m_axis_tready`.
- Full throughput, one beat per cycle, when the sink is always ready. The only bubble is the FLUSH cycle.

## Structure
- Shared package `axis_pkg` holds:
  - keep helpers `keep_ones_right(n)`, `keep_ones_left(n)`, `keep_count(k)`;
  - state enum `offset_state_e`.
- One combinational sub-module, `axis_byte_rotate`. It rotates data and keep left by OFF lanes and is reused by the aligner's counterpart path.

## Test plan
- KW=8, OFF=3. In: beat0 full, bytes 00..07; beat1 keep 0x0F, bytes 08..0B. Out:
  - beat0 keep 0xF8, lanes 3..7 = 00..04;
  - beat1 keep 0x7F = 05..0B, tlast.
- OFF=3, beat1 keep 0x3F (bytes 08..0D). Out:
  - beat0 keep 0xF8;
  - beat1 keep 0xFF = 05..0C;
  - beat2 keep 0x01 = 0D, tlast.
- Single beat, OFF=6:
  - keep 0x07 (bytes 00..02) → beat0 keep 0xC0 = 00,01, then beat1 keep 0x01 = 02, tlast.
  - keep 0x03 → one beat, keep 0x03, tlast, unshifted.
- OFF=0, 5-beat packet → identical 5 beats, identical keep, data and last.
- `m_axis_tready` held low for 5 cycles with the FLUSH beat pending:
  - `s_axis_tready`=0 throughout;
  - output stable;
  - no byte lost or duplicated.
- `rst_n` pulsed low mid-packet → all outputs 0 asynchronously. The next packet is emitted correctly from its first beat.
